uart_tx_scheduler: RTL and testbench

Two-requester transmit scheduler in front of `uart_controller`'s TX side. It arbitrates byte packets from two clients round-robin and holds the grant until the packet's last byte. It drives `uart_tx_data`/`uart_tx_enable` as registered single-cycle pulses. Because the TX path has no busy indication, it paces pulses by a fixed frame interval computed from `CLK_FREQ`/`UART_BAUD`.

---
 rtl/uart_tx_scheduler.sv | 132 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Two-client round-robin byte scheduler feeding a UART TX path that has no busy flag.
// Holds the grant for a whole packet and paces start pulses by a fixed frame interval.
module uart_tx_scheduler #(
  parameter logic [31:0] CLK_FREQ      = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD     = 32'd115200,
  parameter int unsigned STOP_GAP_BITS = 1
) (
  input  logic       uart_clk_in,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_enable,
  output logic [1:0] grant,
  output logic       tx_busy
);

  localparam int unsigned BIT_CYCLES   = CLK_FREQ / UART_BAUD;
  localparam int unsigned FRAME_CYCLES = BIT_CYCLES * (32'd10 + STOP_GAP_BITS);
  // The transfer cycle and the GAP->ACCEPT hop account for the missing two cycles.
  localparam logic [15:0] GAP_LOAD     = 16'(FRAME_CYCLES - 32'd2);

  if (FRAME_CYCLES < 2 || FRAME_CYCLES >= 65536) begin : g_frame_range_check
    $error("uart_tx_scheduler: FRAME_CYCLES must be in [2, 65535]");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    GAP
  } state_e;

  state_e      state_q,     state_d;
  logic        owner_q,     owner_d;
  logic        rr_next_q,   rr_next_d;
  logic [15:0] gap_cnt_q,   gap_cnt_d;
  logic        last_flag_q, last_flag_d;
  logic [7:0]  tx_data_q,   tx_data_d;
  logic        tx_en_q,     tx_en_d;
  logic [1:0]  grant_q,     grant_d;

  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;

  always_comb begin
    own_valid = owner_q ? req1_valid : req0_valid;
    own_data  = owner_q ? req1_data  : req0_data;
    own_last  = owner_q ? req1_last  : req0_last;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_next_d   = rr_next_q;
    gap_cnt_d   = gap_cnt_q;
    last_flag_d = last_flag_q;
    tx_data_d   = tx_data_q;
    tx_en_d     = 1'b0;
    grant_d     = grant_q;

    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d = (req0_valid && req1_valid) ? rr_next_q : req1_valid;
          grant_d = owner_d ? 2'b10 : 2'b01;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (own_valid) begin
          tx_data_d   = own_data;
          tx_en_d     = 1'b1;
          last_flag_d = own_last;
          gap_cnt_d   = GAP_LOAD;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end else if (last_flag_q) begin
          rr_next_d = ~owner_q;
          grant_d   = '0;
          state_d   = IDLE;
        end else begin
          state_d = ACCEPT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge uart_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_next_q   <= 1'b0;
      gap_cnt_q   <= '0;
      last_flag_q <= 1'b0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_next_q   <= rr_next_d;
      gap_cnt_q   <= gap_cnt_d;
      last_flag_q <= last_flag_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      grant_q     <= grant_d;
    end
  end

  assign req0_ready     = (state_q == ACCEPT) && !owner_q;
  assign req1_ready     = (state_q == ACCEPT) &&  owner_q;
  assign uart_tx_data   = tx_data_q;
  assign uart_tx_enable = tx_en_q;
  assign grant          = grant_q;
  assign tx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: queue-fed clients, enable-event log,
// and a packet-level predictor of enable times and byte order.
module tb_uart_tx_scheduler;

  localparam int unsigned F = 4774;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, uart_tx_enable, tx_busy;
  logic [7:0] uart_tx_data;
  logic [1:0] grant;

  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [7:0]  q0_d[$], q1_d[$];
  bit          q0_l[$], q1_l[$];
  bit          force_all = 1'b0;
  int unsigned en_cyc[$];
  logic [7:0]  en_dat[$];
  int unsigned exp_cyc[$];
  logic [7:0]  exp_dat[$];

  uart_tx_scheduler #(
    .CLK_FREQ     (32'd50_000_000),
    .UART_BAUD    (32'd115200),
    .STOP_GAP_BITS(1)
  ) dut (
    .uart_clk_in   (clk),
    .reset_n       (rst_n),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_last     (req0_last),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_last     (req1_last),
    .req1_ready    (req1_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_enable(uart_tx_enable),
    .grant         (grant),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && uart_tx_enable === 1'b1) begin
      en_cyc.push_back(cyc);
      en_dat.push_back(uart_tx_data);
    end
  end

  // Client driver: a byte leaves its queue once it was offered with ready high.
  initial begin
    bit acc0, acc1;
    forever begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (acc0 && q0_d.size() > 0) begin void'(q0_d.pop_front()); void'(q0_l.pop_front()); end
      if (acc1 && q1_d.size() > 0) begin void'(q1_d.pop_front()); void'(q1_l.pop_front()); end
      if (force_all) begin
        req0_valid = 1'b1; req0_data = 8'hFF; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hFF; req1_last = 1'b1;
      end else begin
        req0_valid = q0_d.size() > 0;
        req0_data  = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        req0_last  = (q0_l.size() > 0) ? q0_l[0] : 1'b0;
        req1_valid = q1_d.size() > 0;
        req1_data  = (q1_d.size() > 0) ? q1_d[0] : 8'h00;
        req1_last  = (q1_l.size() > 0) ? q1_l[0] : 1'b0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Packet-level model: both clients hold all their bytes from the start, rr starts at 0.
  function automatic void predict(input logic [7:0] d0[$], input bit l0[$],
                                  input logic [7:0] d1[$], input bit l1[$],
                                  input int unsigned base);
    int unsigned t = base;
    bit rr = 1'b0;
    bit own, lst, more;
    logic [7:0] dat;
    exp_cyc.delete();
    exp_dat.delete();
    while (d0.size() + d1.size() > 0) begin
      if (d0.size() > 0 && d1.size() > 0) own = rr;
      else own = (d1.size() > 0);
      more = 1'b1;
      while (more) begin
        if (own) begin dat = d1.pop_front(); lst = l1.pop_front(); end
        else     begin dat = d0.pop_front(); lst = l0.pop_front(); end
        exp_cyc.push_back(t);
        exp_dat.push_back(dat);
        t += F;
        more = !lst && (own ? d1.size() > 0 : d0.size() > 0);
      end
      rr = !own;
      t += 1;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    force_all = 1'b0;
    q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
    en_cyc.delete(); en_dat.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    force_all = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({grant, tx_busy, req0_ready, req1_ready, uart_tx_enable, uart_tx_data} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got grant=%b busy=%b rdy=%b%b en=%b data=%h, expected all 0",
               grant, tx_busy, req0_ready, req1_ready, uart_tx_enable, uart_tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (grant !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_first_grant: got %b expected 01", grant);
    end
    compared++;
    if (tx_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_first_busy: got %b expected 1", tx_busy);
    end
    force_all = 1'b0;
  endtask

  task automatic test_single_byte();
    int unsigned c;
    do_reset();
    @(negedge clk);
    c = cyc;
    q0_d.push_back(8'hA5); q0_l.push_back(1'b1);
    while (cyc < c + 5) begin
      @(negedge clk);
      compared++;
      if (req0_ready !== (cyc == c + 2)) begin
        mismatched++;
        $display("FAIL single_ready@%0d: got %b expected %b", cyc - c, req0_ready, (cyc == c + 2));
      end
      compared++;
      if (uart_tx_enable !== (cyc == c + 3)) begin
        mismatched++;
        $display("FAIL single_enable@%0d: got %b expected %b", cyc - c, uart_tx_enable, (cyc == c + 3));
      end
    end
    compared++;
    if (en_dat.size() != 1 || en_dat[0] !== 8'hA5) begin
      mismatched++;
      $display("FAIL single_data: got %0d events first=%h expected 1 event A5",
               en_dat.size(), (en_dat.size() > 0) ? en_dat[0] : 8'hxx);
    end
    while (cyc < c + 1 + F) @(negedge clk);
    compared++;
    if (grant !== 2'b01 || tx_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_hold_before_end: got grant=%b busy=%b expected 01/1", grant, tx_busy);
    end
    @(negedge clk);
    compared++;
    if (grant !== 2'b00 || tx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle_after_frame: got grant=%b busy=%b expected 00/0", grant, tx_busy);
    end
  endtask

  task automatic test_packet_lock();
    int unsigned c, viol;
    do_reset();
    @(negedge clk);
    c = cyc;
    q0_d = '{8'h11, 8'h22, 8'h33}; q0_l = '{1'b0, 1'b0, 1'b1};
    q1_d = '{8'h44};               q1_l = '{1'b1};
    predict(q0_d, q0_l, q1_d, q1_l, c + 3);
    viol = 0;
    while (en_cyc.size() < 4 && cyc < c + 3 * F + 40) begin
      @(negedge clk);
      if (req1_ready === 1'b1 && en_cyc.size() < 3) viol++;
    end
    compared++;
    if (viol != 0) begin
      mismatched++;
      $display("FAIL lock_req1_ready: got %0d cycles with req1_ready during req0 packet, expected 0", viol);
    end
    compared++;
    if (en_cyc.size() != exp_cyc.size()) begin
      mismatched++;
      $display("FAIL lock_count: got %0d enables expected %0d", en_cyc.size(), exp_cyc.size());
    end
    for (int i = 0; i < exp_cyc.size() && i < en_cyc.size(); i++) begin
      compared++;
      if (en_cyc[i] !== exp_cyc[i] || en_dat[i] !== exp_dat[i]) begin
        mismatched++;
        $display("FAIL lock_enable[%0d]: got cyc+%0d data %h expected cyc+%0d data %h",
                 i, en_cyc[i] - c, en_dat[i], exp_cyc[i] - c, exp_dat[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int unsigned c;
    do_reset();
    @(negedge clk);
    c = cyc;
    q0_d = '{8'h01, 8'h02}; q0_l = '{1'b1, 1'b1};
    q1_d = '{8'h81, 8'h82}; q1_l = '{1'b1, 1'b1};
    predict(q0_d, q0_l, q1_d, q1_l, c + 3);
    while (en_cyc.size() < 4 && cyc < c + 3 * F + 40) @(negedge clk);
    compared++;
    if (en_cyc.size() != exp_cyc.size()) begin
      mismatched++;
      $display("FAIL rr_count: got %0d enables expected %0d", en_cyc.size(), exp_cyc.size());
    end
    for (int i = 0; i < exp_cyc.size() && i < en_cyc.size(); i++) begin
      compared++;
      if (en_cyc[i] !== exp_cyc[i] || en_dat[i] !== exp_dat[i]) begin
        mismatched++;
        $display("FAIL rr_enable[%0d]: got cyc+%0d data %h expected cyc+%0d data %h",
                 i, en_cyc[i] - c, en_dat[i], exp_cyc[i] - c, exp_dat[i]);
      end
    end
  endtask

  task automatic test_owner_stall();
    int unsigned c, s, viol;
    logic [7:0] d1;
    do_reset();
    d1 = 8'($urandom);
    @(negedge clk);
    c = cyc;
    q0_d.push_back(8'h10); q0_l.push_back(1'b0);
    q1_d.push_back(d1);    q1_l.push_back(1'b1);
    while (en_cyc.size() < 1 && cyc < c + 20) @(negedge clk);
    viol = 0;
    while (cyc < c + 3 + 10000) begin
      @(negedge clk);
      if (grant !== 2'b01 || req1_ready !== 1'b0 || uart_tx_enable !== 1'b0) viol++;
    end
    compared++;
    if (viol != 0) begin
      mismatched++;
      $display("FAIL stall_hold: got %0d bad cycles (grant/req1_ready/enable) expected 0", viol);
    end
    s = cyc;
    q0_d.push_back(8'h20); q0_l.push_back(1'b1);
    exp_cyc = '{c + 3, s + 2, s + 3 + F};
    exp_dat = '{8'h10, 8'h20, d1};
    while (en_cyc.size() < 3 && cyc < s + F + 40) @(negedge clk);
    compared++;
    if (en_cyc.size() != 3) begin
      mismatched++;
      $display("FAIL stall_count: got %0d enables expected 3", en_cyc.size());
    end
    for (int i = 0; i < 3 && i < en_cyc.size(); i++) begin
      compared++;
      if (en_cyc[i] !== exp_cyc[i] || en_dat[i] !== exp_dat[i]) begin
        mismatched++;
        $display("FAIL stall_enable[%0d]: got cyc+%0d data %h expected cyc+%0d data %h",
                 i, en_cyc[i] - c, en_dat[i], exp_cyc[i] - c, exp_dat[i]);
      end
    end
  endtask

  task automatic test_midgap_reset();
    int unsigned c, e2, r;
    logic [7:0] a2, b2;
    do_reset();
    @(negedge clk);
    c = cyc;
    q0_d.push_back(8'($urandom)); q0_l.push_back(1'b1);
    q1_d.push_back(8'($urandom)); q1_l.push_back(1'b1);
    while (en_cyc.size() < 2 && cyc < c + F + 40) @(negedge clk);
    e2 = cyc;
    while (cyc < e2 + 100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({grant, tx_busy, req0_ready, req1_ready, uart_tx_enable, uart_tx_data} !== 14'h0) begin
      mismatched++;
      $display("FAIL midgap_async_clear: got grant=%b busy=%b rdy=%b%b en=%b data=%h, expected all 0",
               grant, tx_busy, req0_ready, req1_ready, uart_tx_enable, uart_tx_data);
    end
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
    q0_d.push_back(a2); q0_l.push_back(1'b1);
    q1_d.push_back(b2); q1_l.push_back(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    @(negedge clk);
    compared++;
    if (grant !== 2'b01 || req0_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midgap_regrant@+%0d: got grant=%b ready0=%b expected 01/1", cyc - r, grant, req0_ready);
    end
    @(negedge clk);
    compared++;
    if (uart_tx_enable !== 1'b1 || uart_tx_data !== a2) begin
      mismatched++;
      $display("FAIL midgap_first_enable@+%0d: got en=%b data=%h expected 1/%h",
               cyc - r, uart_tx_enable, uart_tx_data, a2);
    end
  endtask

  task automatic test_random_packets();
    int unsigned c, n0;
    logic [7:0] d;
    do_reset();
    n0 = $urandom_range(1, 3);
    @(negedge clk);
    c = cyc;
    for (int unsigned i = 0; i < 4; i++) begin
      d = 8'($urandom);
      if (i < n0) begin q0_d.push_back(d); q0_l.push_back((i == n0 - 1) || ($urandom_range(0, 1) == 1)); end
      else        begin q1_d.push_back(d); q1_l.push_back((i == 3)      || ($urandom_range(0, 1) == 1)); end
    end
    predict(q0_d, q0_l, q1_d, q1_l, c + 3);
    while (en_cyc.size() < 4 && cyc < c + 3 * F + 40) @(negedge clk);
    compared++;
    if (en_cyc.size() != exp_cyc.size()) begin
      mismatched++;
      $display("FAIL rand_count: got %0d enables expected %0d", en_cyc.size(), exp_cyc.size());
    end
    for (int i = 0; i < exp_cyc.size() && i < en_cyc.size(); i++) begin
      compared++;
      if (en_cyc[i] !== exp_cyc[i] || en_dat[i] !== exp_dat[i]) begin
        mismatched++;
        $display("FAIL rand_enable[%0d]: got cyc+%0d data %h expected cyc+%0d data %h",
                 i, en_cyc[i] - c, en_dat[i], exp_cyc[i] - c, exp_dat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_packet_lock();
    test_round_robin();
    test_owner_stall();
    test_midgap_reset();
    test_random_packets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
